// File: rtl/cmd_dispatch_pkg.sv
// Shared definitions for the command dispatcher: default opcode base,
// channel indices of the command engines, FSM state and decode actions.
package cmd_dispatch_pkg;

  // Opcode that maps onto channel 0.
  localparam logic [7:0] OPCODE_BASE_DEF = 8'h01;

  // Channel indices of the command engines.
  localparam int CH_SWAP      = 0;
  localparam int CH_CLEAN     = 1;
  localparam int CH_VTX_BEG   = 2;
  localparam int CH_VTX_CONT  = 3;
  localparam int CH_EDGE_BEG  = 4;
  localparam int CH_EDGE_CONT = 5;
  localparam int CH_STATUS    = 7;

  // Dispatcher FSM states. GAP absorbs the FIFO pop and engine busy latency.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

  // What the dispatcher does with the FIFO head in the current cycle.
  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,  // FIFO empty or not looking at the head
    ACT_HOLD  = 2'd1,  // head present, target busy or locked
    ACT_DROP  = 2'd2,  // head carries an illegal opcode
    ACT_ISSUE = 2'd3   // head goes to its engine
  } action_e;

  // Counter/index width that never collapses to zero bits.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmd_dispatch_lock.sv
// Per-channel frame lock register. A channel that takes a lock keeps it
// until the next frame boundary; a set in the same cycle as the frame
// boundary survives, so the lock lasts into the following frame.
module cmd_lock_bank
  import cmd_dispatch_pkg::*;
#(
  parameter int               N_CMD     = 8,
  parameter logic [N_CMD-1:0] LOCK_MASK = N_CMD'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CMD-1:0] set_i,
  input  logic             clr_i,
  output logic [N_CMD-1:0] lock_o
);

  logic [N_CMD-1:0] lock_q;
  logic [N_CMD-1:0] lock_d;

  // Clear on frame boundary first, then OR in new sets so the set wins.
  always_comb begin
    lock_d = (lock_q & ~{N_CMD{clr_i}}) | (set_i & LOCK_MASK);
  end

  // Lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with <= so every flop samples the pre-edge values.
    if (!rst_n) begin
      lock_q <= '0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign lock_o = lock_q;

endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher between the packet FIFO and the command engines.
// Looks at the FWFT FIFO head, pops it only when its engine is free and
// its frame lock is clear, emits a one-hot command pulse plus a latched
// copy of the packet, drops illegal opcodes and watches for long stalls.
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter int               SIZE        = 256,
  parameter int               N_CMD       = 8,
  parameter int               OPCODE_BYTE = 2,
  parameter logic [7:0]       OPCODE_BASE = OPCODE_BASE_DEF,
  parameter logic [N_CMD-1:0] HOLD_MASK   = {N_CMD{1'b1}},
  parameter logic [N_CMD-1:0] LOCK_MASK   = N_CMD'(1),
  parameter int               STALL_LIMIT = 1048576,
  parameter int               CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fifo_empty_i,
  input  logic [8*SIZE-1:0]   fifo_data_i,
  output logic                rd_en_o,
  input  logic [N_CMD-1:0]    busy_i,
  input  logic                frame_event_i,
  input  logic                clr_err_i,
  output logic [N_CMD-1:0]    cmd_o,
  output logic [7:0]          opcode_o,
  output logic [8*SIZE-1:0]   packet_o,
  output logic                packet_ready_o,
  output logic [N_CMD-1:0]    lock_o,
  output logic                stalled_o,
  output logic                err_opcode_o,
  output logic                err_stall_o,
  output logic [CNT_W-1:0]    drop_cnt_o
);

  localparam int PKT_W   = 8 * SIZE;
  localparam int CH_W    = width_of(N_CMD);
  localparam int STALL_W = width_of(STALL_LIMIT);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

  // FSM and decode
  state_e           state_q;
  state_e           state_d;
  action_e          action;

  // Head inspection
  logic [7:0]       head_op;
  logic [8:0]       head_rel;
  logic             head_legal;
  logic [CH_W-1:0]  head_ch;
  logic [N_CMD-1:0] head_onehot;
  logic             head_hold;

  // Registered outputs and their next-state values
  logic             rd_en_q,        rd_en_d;
  logic [N_CMD-1:0] cmd_q,          cmd_d;
  logic             ready_q,        ready_d;
  logic             err_opcode_q,   err_opcode_d;
  logic             stalled_q,      stalled_d;
  logic             err_stall_q,    err_stall_d;
  logic [CNT_W-1:0] drop_cnt_q,     drop_cnt_d;
  logic [7:0]       opcode_q;
  logic [PKT_W-1:0] packet_q;

  // Watchdog
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               stall_hit;

  // Lock bank interface
  logic [N_CMD-1:0] lock;
  logic [N_CMD-1:0] lock_set;

  // Opcode relative to the base, computed one bit wider so an opcode
  // below the base shows up as a negative (bit 8 set) value.
  assign head_op     = fifo_data_i[OPCODE_BYTE*8 +: 8];
  assign head_rel    = {1'b0, head_op} - {1'b0, OPCODE_BASE};
  assign head_legal  = ~head_rel[8] & (head_rel < 9'(N_CMD));
  assign head_ch     = head_rel[CH_W-1:0];
  assign head_onehot = N_CMD'(1) << head_ch;

  // Hold when the target engine is busy (if gated) or its lock is set.
  always_comb begin
    head_hold = |(head_onehot & ((HOLD_MASK & busy_i) | (LOCK_MASK & lock)));
  end

  // Classify what happens to the FIFO head this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    action = ACT_NONE;
    if ((state_q == ST_IDLE) && !fifo_empty_i) begin
      if (!head_legal) begin
        action = ACT_DROP;
      end else if (head_hold) begin
        action = ACT_HOLD;
      end else begin
        action = ACT_ISSUE;
      end
    end
  end

  // Next-state logic: FSM, output pulses, drop counter and watchdog.
  always_comb begin
    state_d      = state_q;
    rd_en_d      = 1'b0;
    cmd_d        = '0;
    ready_d      = 1'b0;
    err_opcode_d = 1'b0;
    stalled_d    = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    err_stall_d  = err_stall_q;
    stall_hit    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if ((action == ACT_DROP) || (action == ACT_ISSUE)) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    unique case (action)
      ACT_DROP: begin
        rd_en_d      = 1'b1;
        err_opcode_d = 1'b1;
        stall_cnt_d  = '0;
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
      end
      ACT_ISSUE: begin
        rd_en_d     = 1'b1;
        cmd_d       = head_onehot;
        ready_d     = 1'b1;
        stall_cnt_d = '0;
      end
      ACT_HOLD: begin
        stalled_d = 1'b1;
        // Counter parks on its last value; err_stall keeps being set while held.
        if (stall_cnt_q == STALL_LAST) begin
          stall_hit = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
      end
      default: begin
        // Empty FIFO in IDLE restarts the watchdog; GAP leaves it alone.
        if (state_q == ST_IDLE) begin
          stall_cnt_d = '0;
        end
      end
    endcase

    // A new timeout beats a simultaneous clear.
    if (stall_hit) begin
      err_stall_d = 1'b1;
    end else if (clr_err_i) begin
      err_stall_d = 1'b0;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_en_q      <= 1'b0;
      cmd_q        <= '0;
      ready_q      <= 1'b0;
      err_opcode_q <= 1'b0;
      stalled_q    <= 1'b0;
      err_stall_q  <= 1'b0;
      drop_cnt_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      cmd_q        <= cmd_d;
      ready_q      <= ready_d;
      err_opcode_q <= err_opcode_d;
      stalled_q    <= stalled_d;
      err_stall_q  <= err_stall_d;
      drop_cnt_q   <= drop_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Latched copy of the last issued packet and its opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this wide data register is reset on purpose: packet_o is an output whose reset value must read as zero.
      opcode_q <= '0;
      packet_q <= '0;
    end else if (action == ACT_ISSUE) begin
      opcode_q <= head_op;
      packet_q <= fifo_data_i;
    end
  end

  assign lock_set = (action == ACT_ISSUE) ? head_onehot : '0;

  cmd_lock_bank #(
    .N_CMD     (N_CMD),
    .LOCK_MASK (LOCK_MASK)
  ) u_lock_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_i  (lock_set),
    .clr_i  (frame_event_i),
    .lock_o (lock)
  );

  assign rd_en_o        = rd_en_q;
  assign cmd_o          = cmd_q;
  assign packet_ready_o = ready_q;
  assign err_opcode_o   = err_opcode_q;
  assign stalled_o      = stalled_q;
  assign err_stall_o    = err_stall_q;
  assign drop_cnt_o     = drop_cnt_q;
  assign opcode_o       = opcode_q;
  assign packet_o       = packet_q;
  assign lock_o         = lock;

endmodule
